// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants and types for the iterative multiply/divide unit
package mdu_pkg;

    localparam int MDU_WIDTH = 16;
    localparam int ITERS     = 16;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 16-bit multiply/divide unit owning the HI/LO register pair
module mul_div_unit #(
    parameter int WIDTH = mdu_pkg::MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operando1,
    input  logic [WIDTH-1:0] operando2,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] mulH,
    output logic [WIDTH-1:0] mulL
);
    import mdu_pkg::*;

    localparam int CW = $clog2(ITERS);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    // acc_q holds {partial product, remaining multiplier} for MUL and
    // {partial remainder, dividend/quotient} for DIVU, shifting one bit per cycle.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] neg_acc;
    logic [WIDTH-1:0]   abs1, abs2;

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, opa_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opa_q;
    assign neg_acc   = -acc_q;
    assign abs1      = operando1[WIDTH-1] ? -operando1 : operando1;
    assign abs2      = operando2[WIDTH-1] ? -operando2 : operando2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        opa_d    = opa_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (start && op != OP_RSVD) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                    is_div_d = (op == OP_DIVU);
                    if (op == OP_MULT) begin
                        sign_d = operando1[WIDTH-1] ^ operando2[WIDTH-1];
                        opa_d  = abs1;
                        acc_d  = {{WIDTH{1'b0}}, abs2};
                    end else if (op == OP_MULTU) begin
                        sign_d = 1'b0;
                        opa_d  = operando1;
                        acc_d  = {{WIDTH{1'b0}}, operando2};
                    end else begin
                        sign_d = 1'b0;
                        opa_d  = operando2;
                        acc_d  = {{WIDTH{1'b0}}, operando1};
                    end
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    acc_d = {div_ge ? div_diff : div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(ITERS - 1)) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                {hi_d, lo_d} = sign_q ? neg_acc : acc_q;
                if (is_div_q && opa_q == '0) dz_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            opa_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            opa_q    <= opa_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign mulH     = hi_q;
    assign mulL     = lo_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 16-bit multiply/divide unit that owns the HI/LO register pair feeding the ALU's `mulH`/`mulL` inputs (ALU ops 13/14 read them). It accepts one operation per start pulse and runs a fixed 17-cycle shift-add / restoring-divide sequence. It reports completion with a one-cycle `done` pulse. It also services direct HI/LO writes from the register-move instructions.

## Interface
- `WIDTH`, 16, operand width; HI/LO are each `WIDTH` bits.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, active-low, asynchronous
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIVU, 11 reserved
- `operando1`  in  WIDTH  multiplicand / dividend
- `operando2`  in  WIDTH  multiplier / divisor
- `wr_hi`, `wr_lo`  in  1 each  direct write enables
- `wdata`  in  WIDTH  direct write data
- `busy`  out  1  high while an operation is in flight
- `done`  out  1  one-cycle completion pulse
- `div_zero`  out  1  last DIVU had divisor 0; sticky until the next accepted start
- `mulH`, `mulL`  out  WIDTH  HI/LO registers to the ALU

## Operation
- FSM states: IDLE, CALC, FINISH. `busy` = (state != IDLE).
- **IDLE**
  - `start` with op 00/01/10 → CALC.
  - Latches the operands, clears `div_zero`, and sets iteration count = 0.
  - MULT latches |operando1| and |operando2|, and records sign = op1[15] ^ op2[15]. |0x8000| = 0x8000 unsigned.
  - `start` with op 11 is ignored: no state change, no `done`.
- **CALC**: one iteration per cycle, 16 cycles (count 0..15), then → FINISH.
  - MUL: 32-bit product register, shift-add, one multiplier bit per cycle.
  - DIVU: restoring division, one quotient bit per cycle, 17-bit partial remainder.
- **FINISH**: completes the result and returns to IDLE.
  - Writes HI/LO and pulses `done`.
  - MULT with sign=1 writes the 32-bit two's-complement negation.
  - MUL: HI = product[31:16], LO = product[15:0].
  - DIVU: LO = quotient, HI = remainder.
  - DIVU by 0 is not special-cased: the natural restoring result is LO = 0xFFFF, HI = dividend. `div_zero` is set.
- **Direct writes**
  - `wr_hi`/`wr_lo` load `wdata` in IDLE only, and may both be high at once.
  - They are dropped while busy.
  - They are dropped in the cycle a `start` is accepted (start wins).
- HI/LO change only in FINISH or on a direct write; they hold otherwise.

## Timing
- Reset (async, any state, including mid-CALC):
  - state = IDLE, `mulH` = `mulL` = 0, `busy` = `done` = `div_zero` = 0.
  - The operation in flight is discarded.
- `start` accepted at edge E0. CALC runs on edges E1..E16. E17 executes FINISH.
  - `busy` is high from after E0 through E17.
  - `done` = 1 and the new HI/LO are visible after E17, for exactly one cycle. `busy` is already 0 in that cycle.
- Back-to-back: a `start` in the `done` cycle is accepted (state is IDLE). The throughput is one operation per 18 cycles.
- `start` while busy is ignored and is not queued. Operands need only be valid in the accepting cycle.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `mdu_pkg` holds:
  - `WIDTH` default
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIVU`
  - state enum {IDLE, CALC, FINISH}
  - iteration count constant 16
- Single module with no sub-modules. The shift-add and restore steps are small enough to stay inline.
- The ALU is unchanged; it connects `mulH`/`mulL` directly.

## Test plan
- MULTU 0xFFFF × 0xFFFF → after E17: HI = 0xFFFE, LO = 0x0001. `done` high one cycle. `busy` high for exactly 17 cycles.
- Signed multiplies:
  - MULT 0xFFFE × 0x0003 → HI = 0xFFFF, LO = 0xFFFA (−6).
  - MULT 0x8000 × 0x8000 → HI = 0x4000, LO = 0x0000.
- Division:
  - DIVU 100 / 7 → LO = 0x000E, HI = 0x0002, `div_zero` = 0.
  - DIVU 0x1234 / 0 → LO = 0xFFFF, HI = 0x1234, `div_zero` = 1.
  - A following DIVU 9 / 3 clears `div_zero` at its start and gives LO = 3, HI = 0.
- Busy-time inputs:
  - `start` and `wr_hi` pulsed while busy → ignored; the result matches the original operation.
  - `wr_lo` = 1 with `wdata` = 0x00AA in IDLE → LO = 0x00AA next cycle.
  - `wr_hi` together with an accepted `start` → HI write dropped.
- Reset and reserved op:
  - Assert `rst_n` = 0 at cycle 8 of CALC → HI = LO = 0, `busy` = 0 immediately, no `done` later.
  - op = 11 with `start` → no `busy`, no `done`.
